// File: rtl/logic_gate_unit.sv
`default_nettype none
// ============================================================================
// Module   : logic_gate_unit
// Purpose  : Registered N-input bitwise gate (AND / OR / XOR / NAND) with a
//            valid/ready handshake on both sides, plus an optional
//            truth-table sweep engine. The sweep runs every lane-0 input
//            pattern through the selected gate and counts the ones.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH        bit width of each operand and of the result
//   NIN          number of operands reduced together (2..8)
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   op           00 AND, 01 OR, 10 XOR, 11 NAND (sampled with in_data)
//   in_valid     operand set and op are valid
//   in_ready     block accepts an operand set this cycle
//   in_data      operand k = in_data[k*WIDTH +: WIDTH]
//   out_valid    out_y holds a result
//   out_ready    downstream accepts out_y
//   out_y        registered bitwise result
//   sweep_start  single-cycle sweep request (taken only when idle)
//   sweep_busy   sweep in progress (RUN or DONE)
//   sweep_done   one-cycle pulse when a sweep completes
//   sweep_ones   number of sweep patterns whose lane-0 result was 1
// Build option
//   LOGIC_GATE_UNIT_SWEEP_EN  compiles in the sweep FSM, pattern counter and
//                             ones accumulator. Without it the sweep outputs
//                             are tied to 0 and sweep_start is ignored.
// ============================================================================
module logic_gate_unit #(
  parameter int WIDTH = 1,
  parameter int NIN   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           op,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NIN*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_y,
  input  logic                 sweep_start,
  output logic                 sweep_busy,
  output logic                 sweep_done,
  output logic [NIN:0]         sweep_ones
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;

  // Reduce all NIN operands lane-wise with the selected operation.
  function automatic logic [WIDTH-1:0] reduce_ops(
    input logic [1:0]           f_op,
    input logic [NIN*WIDTH-1:0] f_data
  );
    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] xor_r;
    logic [WIDTH-1:0] res;
    and_r = f_data[WIDTH-1:0];
    or_r  = f_data[WIDTH-1:0];
    xor_r = f_data[WIDTH-1:0];
    for (int k = 1; k < NIN; k++) begin
      and_r = and_r & f_data[k*WIDTH +: WIDTH];
      or_r  = or_r  | f_data[k*WIDTH +: WIDTH];
      xor_r = xor_r ^ f_data[k*WIDTH +: WIDTH];
    end
    case (f_op)
      OP_AND:  res = and_r;
      OP_OR:   res = or_r;
      OP_XOR:  res = xor_r;
      default: res = ~and_r;
    endcase
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // Data path: single-entry output register with valid/ready handshake
  // --------------------------------------------------------------------------
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic             busy_w;
  logic             xfer_w;
  logic [WIDTH-1:0] result_w;

  assign result_w = reduce_ops(op, in_data);
  // The output register may be refilled in the same cycle it drains.
  assign in_ready = !busy_w && (!out_valid_q || out_ready);
  assign xfer_w   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    if (xfer_w) begin
      out_valid_d = 1'b1;
      out_y_d     = result_w;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;

`ifdef LOGIC_GATE_UNIT_SWEEP_EN
  // --------------------------------------------------------------------------
  // Truth-table sweep: IDLE -> RUN (2^NIN patterns) -> DONE -> IDLE
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter is one bit wider than the pattern so the last pattern value
  // never wraps back to zero.
  localparam logic [NIN:0] LAST_PAT = {1'b0, {NIN{1'b1}}};
  localparam logic [NIN:0] CNT_ONE  = {{NIN{1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [1:0]         op_lat_q, op_lat_d;
  logic [NIN:0]       cnt_q, cnt_d;
  logic [NIN:0]       ones_q, ones_d;
  logic [NIN*WIDTH-1:0] pat_w;
  logic [WIDTH-1:0]   sweep_res_w;

  // Operand k lane 0 carries counter bit k; other lanes are zero and unused.
  always_comb begin
    pat_w = '0;
    for (int k = 0; k < NIN; k++) begin
      pat_w[k*WIDTH] = cnt_q[k];
    end
  end

  assign sweep_res_w = reduce_ops(op_lat_q, pat_w);

  always_comb begin
    state_d  = state_q;
    op_lat_d = op_lat_q;
    cnt_d    = cnt_q;
    ones_d   = ones_q;
    case (state_q)
      S_IDLE: begin
        if (sweep_start) begin
          state_d  = S_RUN;
          op_lat_d = op;
          cnt_d    = '0;
          ones_d   = '0;
        end
      end
      S_RUN: begin
        ones_d = ones_q + {{NIN{1'b0}}, sweep_res_w[0]};
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == LAST_PAT) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_lat_q <= 2'b00;
      cnt_q    <= '0;
      ones_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_lat_q <= op_lat_d;
      cnt_q    <= cnt_d;
      ones_q   <= ones_d;
    end
  end

  assign busy_w     = (state_q == S_RUN) || (state_q == S_DONE);
  assign sweep_busy = busy_w;
  assign sweep_done = (state_q == S_DONE);
  assign sweep_ones = ones_q;
`else
  // Sweep engine not built: outputs held at zero, request ignored.
  logic sweep_start_unused;
  assign sweep_start_unused = sweep_start;
  assign busy_w     = 1'b0;
  assign sweep_busy = 1'b0;
  assign sweep_done = 1'b0;
  assign sweep_ones = '0;
`endif

endmodule
`default_nettype wire
